// File: rtl/jtag_master_pkg.sv
// Shared types and TMS sequence constants for the JTAG sequence master.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'd0,
        OP_SHIFT_IR  = 2'd1,
        OP_SHIFT_DR  = 2'd2,
        OP_RUN_IDLE  = 2'd3
    } jtag_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRST,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RUN,
        ST_RESP
    } jtag_state_e;

    // TMS walks from Run-Test/Idle into Shift-IR / Shift-DR, bit 0 first.
    localparam logic [3:0] TMS_PRE_IR    = 4'b0011;
    localparam logic [2:0] TMS_PRE_DR    = 3'b001;
    localparam int         PRE_IR_LEN    = 4;
    localparam int         PRE_DR_LEN    = 3;
    localparam int         POST_LEN      = 2;
    localparam int         RESET_PERIODS = 8;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV cycles low then CLK_DIV high while enabled, parked low otherwise.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic en_i,
    output logic tck_o,
    output logic rise_stb_o,
    output logic fall_stb_o
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic             tck_q;
    logic             tc;

    assign tc = (cnt_q == '0);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_q <= CNT_LOAD;
            tck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= CNT_LOAD;
            tck_q <= 1'b0;
        end else if (tc) begin
            cnt_q <= CNT_LOAD;
            tck_q <= ~tck_q;
        end else begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    // Strobes mark the clk_in edge at which TCK toggles.
    assign tck_o      = tck_q;
    assign rise_stb_o = en_i && tc && !tck_q;
    assign fall_stb_o = en_i && tc && tck_q;

endmodule

// File: rtl/jtag_seq_master.sv
// JTAG master: turns valid/ready commands into TCK/TMS/TDI/TRSTn sequences
// and returns the captured TDO bits.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// TRST  | 8-period TAP reset, TRSTn low for the first two
// PRE   | TMS walk from Run-Test/Idle into Shift-IR or Shift-DR
// SHIFT | len data periods, TMS high on the last (Exit1)
// POST  | Update then back to Run-Test/Idle
// RUN   | len idle TCK periods with TMS low
// RESP  | response held until rsp_ready, TCK parked low
module jtag_seq_master
    import jtag_master_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = $clog2(DATA_W) + 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              jtag_tck,
    output logic              jtag_tms,
    output logic              jtag_tdi,
    output logic              jtag_trst,
    input  logic              jtag_tdo
);

    localparam int               CNT_W   = (LEN_W > 3) ? LEN_W : 3;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    jtag_state_e       state_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] cap_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        tms_seq_q;
    logic              tms_q;
    logic              tdi_q;
    logic              trst_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              busy_q;

    logic [LEN_W-1:0]  eff_len_d;
    logic              tck_en;
    logic              rise_stb;
    logic              fall_stb;

    assign eff_len_d = (cmd_len == '0 || cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign tck_en    = (state_q == ST_TRST) || (state_q == ST_PRE) || (state_q == ST_SHIFT) ||
                       (state_q == ST_POST) || (state_q == ST_RUN);

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk_in     (clk_in),
        .reset      (reset),
        .en_i       (tck_en),
        .tck_o      (jtag_tck),
        .rise_stb_o (rise_stb),
        .fall_stb_o (fall_stb)
    );

    // Every TCK fall is also the start of the next period, so all TMS/TDI
    // updates and phase changes happen on fall_stb.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            cnt_q       <= '0;
            tms_seq_q   <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        busy_q <= 1'b1;
                        len_q  <= eff_len_d;
                        data_q <= cmd_data;
                        cap_q  <= '0;
                        tdi_q  <= 1'b0;
                        case (jtag_op_e'(cmd_op))
                            OP_TAP_RESET: begin
                                state_q <= ST_TRST;
                                cnt_q   <= CNT_W'(RESET_PERIODS - 1);
                                tms_q   <= 1'b1;
                                trst_q  <= 1'b0;
                            end
                            OP_SHIFT_IR: begin
                                state_q   <= ST_PRE;
                                cnt_q     <= CNT_W'(PRE_IR_LEN - 1);
                                tms_seq_q <= TMS_PRE_IR >> 1;
                                tms_q     <= TMS_PRE_IR[0];
                            end
                            OP_SHIFT_DR: begin
                                state_q   <= ST_PRE;
                                cnt_q     <= CNT_W'(PRE_DR_LEN - 1);
                                tms_seq_q <= {1'b0, TMS_PRE_DR} >> 1;
                                tms_q     <= TMS_PRE_DR[0];
                            end
                            default: begin
                                if (cmd_len == '0) begin
                                    state_q     <= ST_RESP;
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= '0;
                                end else begin
                                    state_q <= ST_RUN;
                                    cnt_q   <= CNT_W'(cmd_len - LEN_ONE);
                                    tms_q   <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                ST_TRST: begin
                    if (fall_stb) begin
                        if (cnt_q == '0) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            cnt_q  <= cnt_q - CNT_ONE;
                            trst_q <= (cnt_q != CNT_W'(RESET_PERIODS - 1));
                            tms_q  <= (cnt_q != CNT_ONE);
                        end
                    end
                end
                ST_PRE: begin
                    if (fall_stb) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= CNT_W'(len_q - LEN_ONE);
                            tms_q   <= (len_q == LEN_ONE);
                            tdi_q   <= data_q[0];
                            data_q  <= data_q >> 1;
                        end else begin
                            cnt_q     <= cnt_q - CNT_ONE;
                            tms_q     <= tms_seq_q[0];
                            tms_seq_q <= tms_seq_q >> 1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (rise_stb) begin
                        cap_q <= {jtag_tdo, cap_q[DATA_W-1:1]};
                    end
                    if (fall_stb) begin
                        if (cnt_q == '0) begin
                            state_q <= ST_POST;
                            cnt_q   <= CNT_W'(POST_LEN - 1);
                            tms_q   <= 1'b1;
                            tdi_q   <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_q - CNT_ONE;
                            tms_q  <= (cnt_q == CNT_ONE);
                            tdi_q  <= data_q[0];
                            data_q <= data_q >> 1;
                        end
                    end
                end
                ST_POST: begin
                    if (fall_stb) begin
                        if (cnt_q == '0) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            // Captured bits sit at the top of cap_q; right-align by length.
                            rsp_data_q  <= cap_q >> (LEN_MAX - len_q);
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                            tms_q <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (fall_stb) begin
                        if (cnt_q == '0) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign jtag_tms  = tms_q;
    assign jtag_tdi  = tdi_q;
    assign jtag_trst = trst_q;

endmodule

// File: tb/tb_jtag_seq_master.sv
// Scoreboard bench for jtag_seq_master with a loopback path and a small TAP model.
module tb_jtag_seq_master;

    localparam int DATA_W  = 32;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 6;
    localparam logic [31:0] IDCODE    = 32'h1BEEF0D3;
    localparam logic [4:0]  IR_IDCODE = 5'b00001;

    logic              clk_in    = 1'b0;
    logic              reset     = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              rsp_ready = 1'b0;
    logic [1:0]        cmd_op    = 2'd0;
    logic [LEN_W-1:0]  cmd_len   = '0;
    logic [DATA_W-1:0] cmd_data  = '0;
    logic              cmd_ready, rsp_valid, busy;
    logic              jtag_tck, jtag_tms, jtag_tdi, jtag_trst, jtag_tdo;
    logic [DATA_W-1:0] rsp_data;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int tck_rises = 0;
    int trst_low  = 0;
    logic use_tap = 1'b0;
    logic tms_log[$];

    typedef struct {
        logic [DATA_W-1:0] data;
        int                lat;
        int                acc;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    always @(negedge clk_in) if (!jtag_trst) trst_low <= trst_low + 1;
    always @(posedge jtag_tck) begin
        tck_rises <= tck_rises + 1;
        tms_log.push_back(jtag_tms);
    end

    jtag_seq_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .jtag_tck  (jtag_tck),
        .jtag_tms  (jtag_tms),
        .jtag_tdi  (jtag_tdi),
        .jtag_trst (jtag_trst),
        .jtag_tdo  (jtag_tdo)
    );

    // IEEE 1149.1 TAP with a 5-bit IR, IDCODE and BYPASS registers.
    typedef enum {TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                  SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    tap_t        tap_st  = TLR;
    logic [4:0]  tap_ir  = IR_IDCODE;
    logic [4:0]  tap_isr = '0;
    logic [31:0] tap_dr  = '0;
    logic        tap_tdo = 1'b0;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:  return tms ? TLR  : RTI;
            RTI:  return tms ? SDS  : RTI;
            SDS:  return tms ? SIS  : CDR;
            CDR:  return tms ? E1DR : SHDR;
            SHDR: return tms ? E1DR : SHDR;
            E1DR: return tms ? UDR  : PDR;
            PDR:  return tms ? E2DR : PDR;
            E2DR: return tms ? UDR  : SHDR;
            UDR:  return tms ? SDS  : RTI;
            SIS:  return tms ? TLR  : CIR;
            CIR:  return tms ? E1IR : SHIR;
            SHIR: return tms ? E1IR : SHIR;
            E1IR: return tms ? UIR  : PIR;
            PIR:  return tms ? E2IR : PIR;
            E2IR: return tms ? UIR  : SHIR;
            default: return tms ? SDS : RTI;
        endcase
    endfunction

    always @(posedge jtag_tck or negedge jtag_trst) begin
        if (!jtag_trst) begin
            tap_st <= TLR;
            tap_ir <= IR_IDCODE;
        end else begin
            case (tap_st)
                TLR:  tap_ir  <= IR_IDCODE;
                CIR:  tap_isr <= 5'b00001;
                SHIR: tap_isr <= {jtag_tdi, tap_isr[4:1]};
                UIR:  tap_ir  <= tap_isr;
                CDR:  tap_dr  <= (tap_ir == IR_IDCODE) ? IDCODE : 32'h0;
                SHDR: tap_dr  <= (tap_ir == IR_IDCODE) ? {jtag_tdi, tap_dr[31:1]} : {31'h0, jtag_tdi};
                default: ;
            endcase
            tap_st <= tap_next(tap_st, jtag_tms);
        end
    end

    always @(negedge jtag_tck)
        tap_tdo <= (tap_st == SHDR) ? tap_dr[0] : (tap_st == SHIR) ? tap_isr[0] : 1'b0;

    assign jtag_tdo = use_tap ? tap_tdo : jtag_tdi;

    function automatic int exp_periods(input logic [1:0] op, input int len);
        int n;
        n = (len == 0 || len > DATA_W) ? DATA_W : len;
        case (op)
            2'd0:    return 8;
            2'd1:    return n + 6;
            2'd2:    return n + 5;
            default: return len;
        endcase
    endfunction

    task automatic send_cmd(input logic [1:0] op, input int len,
                            input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp);
        exp_t e;
        int   n = 0;
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
            errors++;
        end
        e.data = exp;
        e.lat  = 1 + 2 * CLK_DIV * exp_periods(op, len);
        e.acc  = cyc;
        sb_q.push_back(e);
        @(negedge clk_in);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int stall);
        exp_t              e;
        int                n = 0;
        logic [DATA_W-1:0] held;
        while (!rsp_valid && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: rsp_valid=%0b required an expected entry", rsp_valid);
            errors++;
            return;
        end
        e = sb_q.pop_front();
        if (rsp_valid !== 1'b1) begin
            $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
            errors++;
            return;
        end
        checks++;
        if (cyc - e.acc !== e.lat) begin
            $display("FAIL rsp_latency: got %0d cycles required %0d", cyc - e.acc, e.lat);
            errors++;
        end
        checks++;
        if (rsp_data !== e.data) begin
            $display("FAIL rsp_data: got %h required %h", rsp_data, e.data);
            errors++;
        end
        checks++;
        if (jtag_tck !== 1'b0) begin
            $display("FAIL tck_at_resp: got %0b required 0", jtag_tck);
            errors++;
        end
        held = rsp_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_in);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== held || jtag_tck !== 1'b0 ||
                cmd_ready !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL stall_hold: cycle %0d valid=%0b data=%h tck=%0b ready=%0b busy=%0b required 1 %h 0 0 1",
                         i, rsp_valid, rsp_data, jtag_tck, cmd_ready, busy, held);
                errors++;
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk_in);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL handshake: valid=%0b ready=%0b busy=%0b required 0 1 0", rsp_valid, cmd_ready, busy);
            errors++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [6:0] obs;
        obs = {cmd_ready, busy, rsp_valid, jtag_tck, jtag_tms, jtag_tdi, jtag_trst};
        checks++;
        if (obs !== 7'b1000101 || rsp_data !== '0) begin
            $display("FAIL %s: ready/busy/valid/tck/tms/tdi/trst=%b data=%h required 1000101 data 0", tag, obs, rsp_data);
            errors++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        check_reset_outputs("reset_held");
        reset = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_shift_dr();
        int                r0;
        logic [12:0]       got_tms, exp_tms;
        logic [DATA_W-1:0] d;
        use_tap = 1'b0;
        tms_log.delete();
        r0 = tck_rises;
        send_cmd(2'd2, 8, 32'hA5, 32'h0000_00A5);
        get_rsp(0);
        checks++;
        if (tck_rises - r0 !== 13) begin
            $display("FAIL dr8_rises: got %0d required 13", tck_rises - r0);
            errors++;
        end
        got_tms = '0;
        exp_tms = '0;
        for (int i = 0; i < 13; i++) begin
            exp_tms[i] = (i == 0) || (i == 10) || (i == 11);
            if (i < tms_log.size()) got_tms[i] = tms_log[i];
        end
        checks++;
        if (got_tms !== exp_tms || tms_log.size() != 13) begin
            $display("FAIL dr8_tms: got %b (%0d periods) required %b", got_tms, tms_log.size(), exp_tms);
            errors++;
        end
        d = $urandom;
        send_cmd(2'd2, 20, d, d & 32'h000F_FFFF);
        get_rsp(0);
        d = $urandom;
        send_cmd(2'd1, 7, d, d & 32'h0000_007F);
        get_rsp(0);
    endtask

    task automatic test_idcode();
        int t0;
        use_tap = 1'b1;
        t0 = trst_low;
        send_cmd(2'd0, 0, 32'hFFFF_FFFF, 32'h0);
        get_rsp(0);
        checks++;
        if (trst_low - t0 !== 8) begin
            $display("FAIL trst_width: got %0d cycles required 8", trst_low - t0);
            errors++;
        end
        send_cmd(2'd2, 32, 32'h0, IDCODE);
        get_rsp(0);
    endtask

    task automatic test_bypass();
        use_tap = 1'b1;
        send_cmd(2'd1, 5, 32'h1F, 32'h01);
        get_rsp(0);
        send_cmd(2'd2, 9, 32'h0FF, 32'h1FE);
        get_rsp(0);
    endtask

    task automatic test_run_idle();
        int r0;
        use_tap = 1'b0;
        r0 = tck_rises;
        send_cmd(2'd3, 0, 32'hDEAD_BEEF, 32'h0);
        get_rsp(0);
        checks++;
        if (tck_rises - r0 !== 0) begin
            $display("FAIL idle0_rises: got %0d required 0", tck_rises - r0);
            errors++;
        end
        r0 = tck_rises;
        send_cmd(2'd3, 5, 32'hFFFF_FFFF, 32'h0);
        get_rsp(0);
        checks++;
        if (tck_rises - r0 !== 5) begin
            $display("FAIL idle5_rises: got %0d required 5", tck_rises - r0);
            errors++;
        end
    endtask

    task automatic test_len_edge();
        int                r0;
        logic [DATA_W-1:0] d;
        use_tap = 1'b0;
        d  = $urandom;
        r0 = tck_rises;
        send_cmd(2'd2, 0, d, d);
        get_rsp(0);
        checks++;
        if (tck_rises - r0 !== 37) begin
            $display("FAIL len0_rises: got %0d required 37", tck_rises - r0);
            errors++;
        end
        d = $urandom;
        send_cmd(2'd2, 40, d, d);
        get_rsp(0);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        use_tap = 1'b0;
        send_cmd(2'd2, 8, 32'h3C, 32'h3C);
        cmd_op    = 2'd3;
        cmd_len   = LEN_W'(2);
        cmd_data  = '0;
        cmd_valid = 1'b1;
        get_rsp(20);
        e.data = '0;
        e.lat  = 1 + 2 * CLK_DIV * 2;
        e.acc  = cyc;
        sb_q.push_back(e);
        @(negedge clk_in);
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL queued_accept: ready=%0b busy=%0b required 0 1", cmd_ready, busy);
            errors++;
        end
        get_rsp(0);
    endtask

    task automatic test_abort();
        int   r0;
        int   n = 0;
        exp_t e;
        logic seen = 1'b0;
        use_tap = 1'b0;
        r0 = tck_rises;
        send_cmd(2'd2, 16, 32'h1234_5678, 32'h5678);
        while (tck_rises < r0 + 7 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (tck_rises < r0 + 7) begin
            $display("FAIL abort_reach_bit3: rises %0d required %0d", tck_rises - r0, 7);
            errors++;
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("abort_immediate");
        @(negedge clk_in);
        check_reset_outputs("abort_next_cycle");
        if (sb_q.size() > 0) e = sb_q.pop_back();
        repeat (6) begin
            @(negedge clk_in);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            $display("FAIL abort_no_rsp: rsp_valid seen=%0b required 0", seen);
            errors++;
        end
        reset = 1'b1;
        @(negedge clk_in);
        send_cmd(2'd2, 8, 32'h5A, 32'h5A);
        get_rsp(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_in);
        test_reset();
        test_shift_dr();
        test_idcode();
        test_bypass();
        test_run_idle();
        test_len_edge();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
